tt_scan: RTL and testbench
==========================

# tt_scan

Sequential truth-table scanner that sits on both sides of a combinational switch-level cell with a 4-bit input `x` and a 1-bit output `y`. It is the stage upstream that drives `x` and the stage downstream that consumes `y`. On `start` it steps `x` through all 16 codes, waits a programmable settle time per code and samples `y` into a 16-bit table. Optionally it compares the table against an expected mask and reports a pass flag, a mismatch count and the first failing index.

## Interface
- `SETTLE`, default 2: idle cycles after `x` changes before `y` is sampled; legal range 1..15.
- `EXP`, default 16'h0000: expected truth table; bit k is the expected `y` for `x == k`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle request to begin a scan; honoured only in IDLE.
- `x`  out  4  stimulus to the cell under scan.
- `y`  in  1  cell output; a floating net (pulled down) reads as 0.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the table is complete.
- `tt`  out  16  captured table; bit k is `y` sampled while `x == k`.
- `ok`  out  1  `tt == EXP`; valid when `done` is high and held until the next `start`.
- `err_cnt`  out  5  number of mismatching bits, 0..16.
- `first_err`  out  4  lowest mismatching index; 0 when `err_cnt == 0`.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE → SETTLE when `start` is high.
  - On this transition: `x` ← 0, settle counter ← 0, `tt` ← 0, `err_cnt` ← 0, `first_err` ← 0, `ok` ← 0.
- SETTLE: the counter increments each cycle. When it reaches `SETTLE-1`, the FSM moves to SAMPLE.
- SAMPLE, one cycle:
  - `tt[x]` ← `y`.
  - On mismatch against `EXP[x]`: increment `err_cnt`. If this is the first mismatch, `first_err` ← `x`.
  - If `x == 15`: go to DONE.
  - Otherwise: `x` ← `x+1`, counter ← 0, go to SETTLE.
- DONE, one cycle: `done` = 1. `ok` ← (`err_cnt` == 0) using the final count, including the last sample. Then go to IDLE.
- `x` holds 15 after a scan completes and stays there until the next accepted `start`.
- `start` while the FSM is in SETTLE, SAMPLE or DONE is ignored; it is not queued.
- `start` in the same cycle as `rst`: reset wins.
- `x` increments with 4-bit arithmetic and is never wrapped; the scan terminates at 15.
- `err_cnt` is 5 bits wide so that the value 16 (all bits wrong) is representable.

## Timing
- Reset values: state IDLE, `x`=0, `busy`=0, `done`=0, `tt`=0, `ok`=0, `err_cnt`=0, `first_err`=0.
- `start` is sampled at edge 0.
  - Edge 0: `x`=0 and `busy`=1.
  - Code k is driven for `SETTLE+1` cycles. Its sample is taken at edge `(k+1)*(SETTLE+1)`.
  - The DONE state occupies the cycle after the last sample: `done`=1 during cycle `16*(SETTLE+1)`.
  - Next edge: `busy`=0 and the FSM is back in IDLE.
- With `SETTLE`=2: 48 scan cycles, `done` high in cycle 48, and a new `start` is accepted from cycle 49.
- `y` is sampled directly with no synchroniser; the cell is combinational within the same clock domain.
- `rst` asserted mid-scan: at the next edge all outputs return to their reset values and the partial table is discarded.

## Configuration
- `TT_SCAN_COMPARE_EN`
  - Defined: the comparison logic is built and `ok`, `err_cnt`, `first_err` behave as described above.
  - Undefined: the comparison logic is removed. `ok`, `err_cnt` and `first_err` are tied to 0, and `EXP` is unused.
  - Scan, `tt`, `busy` and `done` are identical in both builds.

## Structure
- Shared package `tt_scan_pkg`:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - `TT_W`=4 and `TT_N`=16;
  - counter width localparam sized from the `SETTLE` range.
- One sub-module, `tt_cmp`: a per-sample comparator and accumulator that owns `err_cnt`, `first_err` and `ok`. It is instantiated only under `TT_SCAN_COMPARE_EN`.

## Test plan
- Reset then idle; bench model `y`=0 everywhere → `x`=0, `busy`=0, `done` never pulses, all outputs 0.
- `SETTLE`=2, `EXP`=16'h0400, model `y = (x==10)` → `done` pulses in cycle 48; `tt`=16'h0400, `ok`=1, `err_cnt`=0.
- Same `EXP`, model `y = x[0]` → `tt`=16'hAAAA, `ok`=0, `err_cnt`=9, `first_err`=1.
- `start` pulsed again at cycle 20 of a scan → ignored; `done` still pulses exactly once, in cycle 48.
- `rst` at cycle 25 mid-scan, then `start` at cycle 30 → after reset all outputs are 0; a full scan completes with `done` in cycle 78.
- Build without `TT_SCAN_COMPARE_EN`, model `y = x[0]` → `tt`=16'hAAAA; `ok`, `err_cnt` and `first_err` stay 0 throughout.

Source files
------------

// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the tt_scan truth-table scanner.
package tt_scan_pkg;

  // Cell under scan: 4 input bits, so a 16-entry truth table.
  localparam int TT_W = 4;
  localparam int TT_N = 16;

  // Legal settle range is 1..15, so the settle counter needs 4 bits.
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = $clog2(SETTLE_MAX + 1);

  // Mismatch counter must be able to represent TT_N itself (all bits wrong).
  localparam int ERR_W = $clog2(TT_N + 1);

  typedef logic [TT_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/tt_scan_if.sv
// Signal bundle between the scanner and its environment (cell under scan,
// requester and result consumer). The scanner takes the slave side.
interface tt_scan_if;
  import tt_scan_pkg::*;

  logic              start;
  idx_t              x;
  logic              y;
  logic              busy;
  logic              done;
  logic [TT_N-1:0]   tt;
  logic              ok;
  logic [ERR_W-1:0]  err_cnt;
  idx_t              first_err;

  // Environment side: requests scans, models the cell, reads the results.
  modport master (
    output start,
    output y,
    input  x,
    input  busy,
    input  done,
    input  tt,
    input  ok,
    input  err_cnt,
    input  first_err
  );

  // Scanner side.
  modport slave (
    input  start,
    input  y,
    output x,
    output busy,
    output done,
    output tt,
    output ok,
    output err_cnt,
    output first_err
  );

endinterface

// File: rtl/tt_scan_cmp.sv
// tt_cmp: per-sample comparator against the expected table. Accumulates the
// mismatch count, remembers the lowest failing index and produces the pass
// flag on the final sample so it is already valid while done is high.
module tt_cmp
  import tt_scan_pkg::*;
#(
  parameter logic [TT_N-1:0] EXP = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_smp,
  input  logic             i_last,
  input  idx_t             i_idx,
  input  logic             i_y,
  output logic             o_ok,
  output logic [ERR_W-1:0] o_err_cnt,
  output idx_t             o_first_err
);

  logic [ERR_W-1:0] r_err_cnt;
  idx_t             r_first_err;
  logic             r_ok;

  logic             w_mis;
  logic [ERR_W-1:0] w_err_nxt;

  assign w_mis     = i_smp & (i_y != EXP[i_idx]);
  assign w_err_nxt = r_err_cnt + ERR_W'(w_mis);

  // Accumulate mismatches; clear on reset or on an accepted start.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_ok        <= 1'b0;
    end else begin
      if (w_mis) begin
        r_err_cnt <= w_err_nxt;
        if (r_err_cnt == '0) begin
          r_first_err <= i_idx;
        end
      end
      // Final count includes the last sample, so judge it here.
      if (i_smp && i_last) begin
        r_ok <= (w_err_nxt == '0);
      end
    end
  end

  assign o_ok        = r_ok;
  assign o_err_cnt   = r_err_cnt;
  assign o_first_err = r_first_err;

endmodule

// File: rtl/tt_scan.sv
// tt_scan: steps x through all 16 codes, waits SETTLE cycles per code and
// samples y into a 16-bit truth table. The optional comparison against EXP
// is built only when TT_SCAN_COMPARE_EN is defined; otherwise ok, err_cnt
// and first_err are tied to 0.
module tt_scan
  import tt_scan_pkg::*;
#(
  parameter int              SETTLE = 2,      // 1..15
  parameter logic [TT_N-1:0] EXP    = '0
) (
  input  logic      clk,
  input  logic      rst,
  tt_scan_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam idx_t             X_LAST   = idx_t'(TT_N - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  idx_t             r_x;
  logic [CNT_W-1:0] r_cnt;
  logic [TT_N-1:0]  r_tt;

  logic w_load;
  logic w_sample;
  logic w_busy;
  logic w_done;
  logic w_last;
  logic w_cnt_last;

  assign w_last     = (r_x == X_LAST);
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start outside IDLE is simply not looked at.
  // NOTE: default assignment first so no path leaves w_state_nxt unassigned
  // (which would infer a latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start)  w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (w_cnt_last) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = w_last ? ST_DONE : ST_SETTLE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    w_load   = 1'b0;
    w_sample = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      ST_IDLE:   w_load = bus.start;
      ST_SETTLE: w_busy = 1'b1;
      ST_SAMPLE: begin
        w_busy   = 1'b1;
        w_sample = 1'b1;
      end
      ST_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Stimulus index, settle counter and captured table.
  // NOTE: the table is an observable output, so it is reset with the rest of
  // the datapath rather than left to power-up state.
  always_ff @(posedge clk) begin
    if (rst || w_load) begin
      r_x   <= '0;
      r_cnt <= '0;
      r_tt  <= '0;
    end else if (w_sample) begin
      r_tt[r_x] <= bus.y;
      // x parks at 15 after the last code; it never wraps.
      if (!w_last) begin
        r_x   <= r_x + idx_t'(1);
        r_cnt <= '0;
      end
    end else if (r_state == ST_SETTLE) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.x    = r_x;
  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.tt   = r_tt;

`ifdef TT_SCAN_COMPARE_EN
  tt_cmp #(
    .EXP (EXP)
  ) u_cmp (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_load),
    .i_smp       (w_sample),
    .i_last      (w_last),
    .i_idx       (r_x),
    .i_y         (bus.y),
    .o_ok        (bus.ok),
    .o_err_cnt   (bus.err_cnt),
    .o_first_err (bus.first_err)
  );
`else
  // Comparison not built: EXP has no consumer.
  logic w_exp_unused;
  assign w_exp_unused  = ^EXP;
  assign bus.ok        = 1'b0;
  assign bus.err_cnt   = '0;
  assign bus.first_err = '0;
`endif

endmodule

// File: tb/tb_tt_scan.sv
// Self-checking bench for tt_scan. The cell under scan is a 16-entry lookup
// driven combinationally from x; expected results come from the table rules.
module tb_tt_scan;
  import tt_scan_pkg::*;

  localparam int              S        = 2;
  localparam logic [15:0]     EXP_TT   = 16'h0400;
  localparam int              SCAN_LEN = 16 * (S + 1);
`ifdef TT_SCAN_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  typedef struct {
    int          done_cyc;
    int          done_pulses;
    int          x_errs;
    int          zero_errs;
    logic [15:0] tt;
    logic        ok;
    logic [4:0]  err;
    logic [3:0]  fe;
  } obs_t;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic [15:0] y_tbl = '0;
  int          n_pass  = 0;
  int          n_total = 0;

  tt_scan_if bus ();
  assign bus.y = y_tbl[bus.x];

  tt_scan #(.SETTLE(S), .EXP(EXP_TT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: ok / mismatch count / first failing index for a table.
  function automatic logic ref_ok(input logic [15:0] t);
    return CMP ? (t == EXP_TT) : 1'b0;
  endfunction

  function automatic logic [4:0] ref_err(input logic [15:0] t);
    int n = 0;
    for (int k = 0; k < 16; k++) if (t[k] != EXP_TT[k]) n++;
    return CMP ? 5'(n) : 5'd0;
  endfunction

  function automatic logic [3:0] ref_fe(input logic [15:0] t);
    for (int k = 0; k < 16; k++) if (t[k] != EXP_TT[k]) return CMP ? 4'(k) : 4'd0;
    return 4'd0;
  endfunction

  // Drive n_cycles edges (start/rst pulsed at chosen edges) and observe.
  // Cycle c is the interval after edge c; observation is at its negedge.
  task automatic run_window(input int start_edge, input int extra_edge,
                            input int rst_edge, input int n_cycles, output obs_t o);
    int k;
    int exp_x;
    logic exp_busy;
    o.done_cyc = -1; o.done_pulses = 0; o.x_errs = 0; o.zero_errs = 0;
    o.tt = 'x; o.ok = 'x; o.err = 'x; o.fe = 'x;
    for (int c = 0; c < n_cycles; c++) begin
      bus.start = (c == start_edge) || (c == extra_edge);
      rst       = (c == rst_edge);
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) begin
        o.done_pulses++;
        if (o.done_cyc < 0) begin
          o.done_cyc = c; o.tt = bus.tt; o.ok = bus.ok;
          o.err = bus.err_cnt; o.fe = bus.first_err;
        end
      end
      if (start_edge >= 0 && c >= start_edge) begin
        k        = c - start_edge;
        exp_x    = (k < SCAN_LEN) ? k / (S + 1) : 15;
        exp_busy = (k <= SCAN_LEN);
        if (bus.x !== 4'(exp_x) || bus.busy !== exp_busy) o.x_errs++;
      end else if (rst_edge >= 0 && c >= rst_edge) begin
        if (bus.x !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.tt !== 16'd0 || bus.ok !== 1'b0 || bus.err_cnt !== 5'd0 ||
            bus.first_err !== 4'd0) o.zero_errs++;
      end
    end
    bus.start = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1; bus.start = 1'b0; y_tbl = '0;
    repeat (3) @(negedge clk);
    n_total++; if (bus.x !== 4'd0) $display("FAIL reset_x: got %0h exp 0", bus.x); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b exp 0", bus.busy); else n_pass++;
    n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %0b exp 0", bus.done); else n_pass++;
    n_total++; if (bus.tt !== 16'd0) $display("FAIL reset_tt: got %0h exp 0", bus.tt); else n_pass++;
    n_total++;
    if ({bus.ok, bus.err_cnt, bus.first_err} !== 10'd0)
      $display("FAIL reset_cmp: got ok=%0b err=%0d fe=%0d exp all 0", bus.ok, bus.err_cnt, bus.first_err);
    else n_pass++;
    rst = 1'b0;
    run_window(-1, -1, 0, 12, o);
    n_total++; if (o.zero_errs !== 0) $display("FAIL idle_zero: got %0d nonzero cycles exp 0", o.zero_errs); else n_pass++;
    n_total++; if (o.done_pulses !== 0) $display("FAIL idle_done: got %0d pulses exp 0", o.done_pulses); else n_pass++;
  endtask

  task automatic test_hot();
    obs_t o;
    for (int k = 0; k < 16; k++) y_tbl[k] = (k == 10);
    run_window(0, -1, -1, SCAN_LEN + 4, o);
    n_total++; if (o.done_cyc !== SCAN_LEN) $display("FAIL hot_done_cyc: got %0d exp %0d", o.done_cyc, SCAN_LEN); else n_pass++;
    n_total++; if (o.done_pulses !== 1) $display("FAIL hot_done_pulses: got %0d exp 1", o.done_pulses); else n_pass++;
    n_total++; if (o.x_errs !== 0) $display("FAIL hot_x_busy: got %0d bad cycles exp 0", o.x_errs); else n_pass++;
    n_total++; if (o.tt !== 16'h0400) $display("FAIL hot_tt: got %0h exp 0400", o.tt); else n_pass++;
    n_total++; if (o.ok !== ref_ok(16'h0400)) $display("FAIL hot_ok: got %0b exp %0b", o.ok, ref_ok(16'h0400)); else n_pass++;
    n_total++; if (o.err !== ref_err(16'h0400)) $display("FAIL hot_err: got %0d exp %0d", o.err, ref_err(16'h0400)); else n_pass++;
    n_total++; if (bus.ok !== ref_ok(16'h0400)) $display("FAIL hot_ok_held: got %0b exp %0b", bus.ok, ref_ok(16'h0400)); else n_pass++;
  endtask

  task automatic test_parity();
    obs_t o;
    for (int k = 0; k < 16; k++) y_tbl[k] = (k % 2 == 1);
    run_window(0, -1, -1, SCAN_LEN + 4, o);
    n_total++; if (o.done_cyc !== SCAN_LEN) $display("FAIL par_done_cyc: got %0d exp %0d", o.done_cyc, SCAN_LEN); else n_pass++;
    n_total++; if (o.tt !== 16'hAAAA) $display("FAIL par_tt: got %0h exp aaaa", o.tt); else n_pass++;
    n_total++; if (o.ok !== ref_ok(16'hAAAA)) $display("FAIL par_ok: got %0b exp %0b", o.ok, ref_ok(16'hAAAA)); else n_pass++;
    n_total++; if (o.err !== ref_err(16'hAAAA)) $display("FAIL par_err: got %0d exp %0d", o.err, ref_err(16'hAAAA)); else n_pass++;
    n_total++; if (o.fe !== ref_fe(16'hAAAA)) $display("FAIL par_first_err: got %0d exp %0d", o.fe, ref_fe(16'hAAAA)); else n_pass++;
    n_total++; if (bus.err_cnt !== ref_err(16'hAAAA)) $display("FAIL par_err_held: got %0d exp %0d", bus.err_cnt, ref_err(16'hAAAA)); else n_pass++;
    n_total++; if (bus.x !== 4'd15) $display("FAIL par_x_park: got %0d exp 15", bus.x); else n_pass++;
  endtask

  task automatic test_start_ignored();
    obs_t o;
    for (int k = 0; k < 16; k++) y_tbl[k] = (k % 2 == 1);
    run_window(0, 20, -1, SCAN_LEN + 12, o);
    n_total++; if (o.done_pulses !== 1) $display("FAIL ign_done_pulses: got %0d exp 1", o.done_pulses); else n_pass++;
    n_total++; if (o.done_cyc !== SCAN_LEN) $display("FAIL ign_done_cyc: got %0d exp %0d", o.done_cyc, SCAN_LEN); else n_pass++;
    n_total++; if (o.x_errs !== 0) $display("FAIL ign_x_busy: got %0d bad cycles exp 0", o.x_errs); else n_pass++;
    n_total++; if (o.tt !== 16'hAAAA) $display("FAIL ign_tt: got %0h exp aaaa", o.tt); else n_pass++;
  endtask

  task automatic test_mid_reset();
    obs_t o1;
    obs_t o2;
    for (int k = 0; k < 16; k++) y_tbl[k] = (k == 10);
    run_window(0, -1, -1, 25, o1);
    n_total++; if (o1.x_errs !== 0) $display("FAIL mr_pre_x_busy: got %0d bad cycles exp 0", o1.x_errs); else n_pass++;
    // Reset at absolute edge 25, start at absolute edge 30.
    run_window(5, -1, 0, 5 + SCAN_LEN + 4, o2);
    n_total++; if (o2.zero_errs !== 0) $display("FAIL mr_zero: got %0d nonzero cycles exp 0", o2.zero_errs); else n_pass++;
    n_total++; if (o2.done_cyc + 25 !== 78) $display("FAIL mr_done_cyc: got %0d exp 78", o2.done_cyc + 25); else n_pass++;
    n_total++; if (o2.done_pulses !== 1) $display("FAIL mr_done_pulses: got %0d exp 1", o2.done_pulses); else n_pass++;
    n_total++; if (o2.x_errs !== 0) $display("FAIL mr_x_busy: got %0d bad cycles exp 0", o2.x_errs); else n_pass++;
    n_total++; if (o2.tt !== 16'h0400) $display("FAIL mr_tt: got %0h exp 0400", o2.tt); else n_pass++;
    n_total++; if (o2.ok !== ref_ok(16'h0400)) $display("FAIL mr_ok: got %0b exp %0b", o2.ok, ref_ok(16'h0400)); else n_pass++;
  endtask

  // Random cell tables, plus the all-bits-wrong boundary (err_cnt == 16).
  task automatic test_random();
    obs_t o;
    logic [15:0] t;
    for (int i = 0; i < 5; i++) begin
      t = (i == 0) ? ~EXP_TT : 16'($urandom);
      y_tbl = t;
      run_window(0, -1, -1, SCAN_LEN + 3, o);
      n_total++; if (o.done_cyc !== SCAN_LEN) $display("FAIL rnd%0d_done_cyc: got %0d exp %0d", i, o.done_cyc, SCAN_LEN); else n_pass++;
      n_total++; if (o.x_errs !== 0) $display("FAIL rnd%0d_x_busy: got %0d bad cycles exp 0", i, o.x_errs); else n_pass++;
      n_total++; if (o.tt !== t) $display("FAIL rnd%0d_tt: got %0h exp %0h", i, o.tt, t); else n_pass++;
      n_total++; if (o.ok !== ref_ok(t)) $display("FAIL rnd%0d_ok: got %0b exp %0b", i, o.ok, ref_ok(t)); else n_pass++;
      n_total++; if (o.err !== ref_err(t)) $display("FAIL rnd%0d_err: got %0d exp %0d", i, o.err, ref_err(t)); else n_pass++;
      n_total++; if (o.fe !== ref_fe(t)) $display("FAIL rnd%0d_first_err: got %0d exp %0d", i, o.fe, ref_fe(t)); else n_pass++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_hot();
    test_parity();
    test_start_ignored();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
